// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: accepts N operand pairs, multiplies each through a 4:2
// compressor tree, registers the product and sums it into a wrapping accumulator.
module mac_seq_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic                 res_ovf,
    output logic                 busy
);
    localparam int PW = 2 * WIDTH;
    // Row count padded to a power of two so every tree level halves cleanly.
    localparam int NR = (WIDTH <= 2) ? 2 : (1 << $clog2(WIDTH));
    localparam int LV = $clog2(NR);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [LEN_WIDTH-1:0]   len, count;
    logic [PW-1:0]          prod, p;
    logic                   pvld;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   ovf;
    logic [ACC_WIDTH:0]     sum;
    logic                   accept, last, start_job;

    logic [NR-1:0]          b_ext;
    logic [PW-1:0]          rows [NR];
    logic [PW-1:0]          nxt  [NR];
    logic [PW-1:0]          s1, c1;

    // Partial products reduced 4 rows -> 2 per level, then one carry-propagate add.
    always_comb begin
        b_ext = NR'(op_b);
        s1    = '0;
        c1    = '0;
        for (int k = 0; k < NR; k++) nxt[k] = '0;
        for (int i = 0; i < NR; i++) rows[i] = b_ext[i] ? (PW'(op_a) << i) : '0;
        for (int lv = 0; lv < LV - 1; lv++) begin
            for (int k = 0; k < NR; k++) nxt[k] = '0;
            for (int k = 0; k < NR / 4; k++) begin
                if (k < (NR >> (lv + 2))) begin
                    s1 = rows[4*k] ^ rows[4*k+1] ^ rows[4*k+2];
                    c1 = ((rows[4*k] & rows[4*k+1]) | (rows[4*k] & rows[4*k+2]) |
                          (rows[4*k+1] & rows[4*k+2])) << 1;
                    nxt[2*k]   = s1 ^ c1 ^ rows[4*k+3];
                    nxt[2*k+1] = ((s1 & c1) | (s1 & rows[4*k+3]) | (c1 & rows[4*k+3])) << 1;
                end
            end
            for (int k = 0; k < NR; k++) rows[k] = nxt[k];
        end
        prod = rows[0] + rows[1];
    end

    assign accept    = op_valid & op_ready;
    assign last      = (count == len - 1'b1);
    assign start_job = (state == IDLE) & start;
    assign sum       = {1'b0, acc} + (ACC_WIDTH + 1)'(p);
    assign res_data  = acc;
    assign res_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (vec_len == '0) ? DONE : RUN;
            end
            RUN: begin
                op_ready = 1'b1;
                if (op_valid && last) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // start and accept are mutually exclusive (IDLE vs RUN), so count has one writer per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len   <= '0;
            count <= '0;
            p     <= '0;
            pvld  <= 1'b0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                p     <= prod;
                pvld  <= 1'b1;
                count <= count + 1'b1;
            end else begin
                pvld  <= 1'b0;
            end
            if (start_job) begin
                acc   <= '0;
                ovf   <= 1'b0;
                count <= '0;
                len   <= vec_len;
            end else if (pvld) begin
                acc   <= sum[ACC_WIDTH-1:0];
                ovf   <= ovf | sum[ACC_WIDTH];
            end
        end
    end
endmodule
